fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of one `fifo` instance among `num_req` producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time, holds the grant for a bounded burst, and forwards that producer's data to the FIFO write port. It sits directly in front of `fifo` and is gated by the FIFO's `full` flag.

## Interface
Parameters:
- `data_width`, default 8: data word width; must equal the attached FIFO's `data_width`.
- `num_req`, default 4: number of requesters, 2..16.
- `max_burst`, default 4: maximum beats accepted per grant, ≥1.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, `num_req`: per-requester data valid.
- `req_data`, in, `num_req*data_width`: packed data; requester i occupies bits `[i*data_width +: data_width]`.
- `req_ready`, out, `num_req`: per-requester accept; at most one bit set.
- `fifo_full`, in, 1: FIFO `full` flag.
- `fifo_wr_en`, out, 1: FIFO write enable.
- `fifo_din`, out, `data_width`: FIFO write data.
- `grant`, out, `num_req`: one-hot current grant, or all zero.
- `busy`, out, 1: high in GRANT state.

## Operation
- Registered state: `state` (IDLE/GRANT), `grant` (one-hot), `last` (index of the last granted requester, `$clog2(num_req)` bits), and `cnt` (beats in the current grant, `$clog2(max_burst)+1` bits).
- Combinational outputs while in GRANT with requester g:
  - `req_ready[g] = !fifo_full`; all other `req_ready` bits are 0.
  - `fifo_wr_en = req_valid[g] & !fifo_full`.
  - `fifo_din = req_data[g]`.
- In IDLE: `req_ready = 0`, `fifo_wr_en = 0`, `fifo_din = 0`.
- A beat is accepted when `req_valid[g] & req_ready[g]`, which is identical to `fifo_wr_en`.
- IDLE → GRANT: when any `req_valid` bit is set, the winner is the first valid index found searching upward from `last+1`, wrapping modulo `num_req`. On this transition `grant` is set to the winner and `cnt` is cleared to 0.
- GRANT, beat accepted with `cnt == max_burst-1`: release.
- GRANT, `req_valid[g] == 0`: release. No beat is transferred that cycle.
- GRANT otherwise: on an accepted beat, `cnt` increments. When `fifo_full` is high, the arbiter holds: `cnt` and `grant` are unchanged and `req_ready` is 0.
- Release: next state is IDLE, `grant` becomes 0, `last` becomes g, `cnt` becomes 0.
- Requesters must hold `req_valid` and `req_data` stable until accepted. Dropping `req_valid` forfeits the grant.
- Fairness: every continuously valid requester is granted within `(num_req-1)*(max_burst+1)+1` cycles of the arbiter entering IDLE.

## Timing
- Reset values: `state = IDLE`, `grant = 0`, `cnt = 0`, `last = num_req-1`, so requester 0 has first priority. Resulting outputs: `req_ready = 0`, `fifo_wr_en = 0`, `fifo_din = 0`, `busy = 0`.
- Reset asserted mid-burst aborts the grant at the next edge. No write is issued in the reset cycle.
- Arbitration latency: the first beat can be accepted 1 cycle after `req_valid` is seen in IDLE.
- Every release inserts exactly one IDLE cycle before the next grant. A full burst therefore occupies `max_burst` GRANT cycles plus 1 IDLE cycle.
- Throughput: with no `fifo_full`, one beat per cycle within a burst.
- `fifo_full` is sampled in the same cycle as the write. Because no write is issued when full, the arbiter never overflows the FIFO.
- If `fifo_full` and a valid drop occur in the same cycle, the drop takes precedence and the grant is released.

## Configuration
- `FIFO_WR_ARB_HIPRI_EN` defined: requester 0 is high-priority. In IDLE it wins whenever `req_valid[0]` is set, regardless of `last`. Its bursts still obey `max_burst`, and `last` is updated normally.
- `FIFO_WR_ARB_HIPRI_EN` undefined: pure round-robin as described in Operation.

## Test plan
- Reset, then `req_valid = 4'b0001` continuously with data 0x10..0x15 → `grant = 0001` from cycle 1. Beats 0x10..0x13 are written, then 1 IDLE cycle, then 0x14 and 0x15 in a new grant.
- `req_valid = 4'b1111` held continuously → grant order is 0, 1, 2, 3, 0. Each grant writes 4 beats followed by 1 IDLE cycle.
- Requester 2 granted, `fifo_full` asserted after beat 2 for 3 cycles → `fifo_wr_en = 0` and `req_ready = 0` for those 3 cycles, `cnt` holds at 2. Beats 3 and 4 follow, then release.
- Requester 1 drops `req_valid` after 1 beat → grant is released next cycle, `last = 1`. The next winner among `4'b1001` is requester 3.
- `rst` asserted mid-burst of requester 3 → next cycle `grant = 0`, `busy = 0`, no write. After reset release with all requesters valid, requester 0 wins first.
- With `FIFO_WR_ARB_HIPRI_EN` defined and `req_valid = 4'b0101` held continuously, with `last = 0` → requester 0 wins every arbitration and requester 2 never wins. Bench confirms this and confirms the build without the macro alternates 0 and 2.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among num_req valid/ready producers.
// Optional macro FIFO_WR_ARB_HIPRI_EN: requester 0 wins every arbitration in which it is valid.
module fifo_wr_arbiter #(
  parameter int data_width = 8,
  parameter int num_req    = 4,
  parameter int max_burst  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [num_req-1:0]            req_valid,
  input  logic [num_req*data_width-1:0] req_data,
  output logic [num_req-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [data_width-1:0]         fifo_din,
  output logic [num_req-1:0]            grant,
  output logic                          busy
);

  localparam int last_w = $clog2(num_req);
  localparam int cnt_w  = $clog2(max_burst) + 1;
  localparam logic [cnt_w-1:0]  cnt_end  = cnt_w'(max_burst - 1);
  localparam logic [last_w-1:0] last_rst = last_w'(num_req - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state, state_n;
  logic [num_req-1:0]  grant_n;
  logic [last_w-1:0]   last, last_n;
  logic [cnt_w-1:0]    cnt, cnt_n;
  logic [last_w-1:0]   g;
  logic [last_w-1:0]   win;
  logic [last_w-1:0]   idx;
  logic                win_found;

  // Index of the currently granted requester (grant is one-hot or zero).
  always_comb begin
    g = '0;
    for (int i = 0; i < num_req; i++)
      if (grant[i]) g = last_w'(i);
  end

  // Round-robin search upward from last+1, wrapping.
  always_comb begin
    win       = last;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 1; k <= num_req; k++) begin
      idx = last_w'((int'(last) + k) % num_req);
      if (!win_found && req_valid[idx]) begin
        win       = idx;
        win_found = 1'b1;
      end
    end
`ifdef FIFO_WR_ARB_HIPRI_EN
    if (req_valid[0]) win = '0;
`endif
  end

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    if (state == GRANT) begin
      fifo_din = req_data[int'(g)*data_width +: data_width];
      // Writes are suppressed while reset is asserted, even before the aborting edge.
      if (!rst && !fifo_full) begin
        req_ready  = grant;
        fifo_wr_en = req_valid[g];
      end
    end
  end

  assign busy = (state == GRANT);

  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n  = last;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_n      = GRANT;
          grant_n      = '0;
          grant_n[win] = 1'b1;
          cnt_n        = '0;
        end
      end
      GRANT: begin
        // A valid drop releases even when fifo_full is high.
        if (!req_valid[g] || (fifo_wr_en && cnt == cnt_end)) begin
          state_n = IDLE;
          grant_n = '0;
          last_n  = g;
          cnt_n   = '0;
        end else if (fifo_wr_en) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last  <= last_rst;
      cnt   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected grants per cycle and expected written words are queued
// when each scenario starts and popped on the falling edge as the DUT produces them.
module tb_fifo_wr_arbiter;

  localparam int dw = 8;
  localparam int nr = 4;
  localparam int mb = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [nr-1:0]    req_valid;
  logic [nr*dw-1:0] req_data;
  logic [nr-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [dw-1:0]    fifo_din;
  logic [nr-1:0]    grant;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;
  int remaining[nr];
  int beat[nr];
  logic [dw-1:0] exp_data[$];
  logic [nr-1:0] exp_grant[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.data_width(dw), .num_req(nr), .max_burst(mb)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .grant(grant), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Producer model: each requester offers remaining[i] beats, data 0x10*(i+1)+beat[i].
  task automatic drive();
    for (int i = 0; i < nr; i++) begin
      req_valid[i]            = (remaining[i] > 0);
      req_data[i*dw +: dw]    = 8'(8'h10 * (i + 1) + beat[i]);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic burst(input int r, input int first, input int n);
    logic [nr-1:0] oh;
    oh = '0; oh[r] = 1'b1;
    for (int k = 0; k < n; k++) begin
      exp_grant.push_back(oh);
      exp_data.push_back(8'(8'h10 * (r + 1) + first + k));
    end
  endtask

  task automatic held(input int r, input int n);
    logic [nr-1:0] oh;
    oh = '0; oh[r] = 1'b1;
    for (int k = 0; k < n; k++) exp_grant.push_back(oh);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) exp_grant.push_back('0);
  endtask

  task automatic drained(input string tag);
    check({tag, "_data_left"}, exp_data.size(), 0);
    check({tag, "_grant_left"}, exp_grant.size(), 0);
    exp_data.delete();
    exp_grant.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < nr; i++) begin remaining[i] = 0; beat[i] = 0; end
    drive();
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_din", fifo_din, 0);
    check("rst_last", dut.last, nr - 1);
    @(posedge clk); #1;
    rst = 1'b0;
    drive();
  endtask

  // Scoreboard side: pop expected grant every scenario cycle, expected word on every write.
  always @(negedge clk) begin
    if (exp_grant.size() > 0) begin
      check("grant", grant, exp_grant.pop_front());
      check("ready_onehot", $onehot0(req_ready), 1);
      check("wr_en_vs_accept", fifo_wr_en, |(req_valid & req_ready));
    end
    if (fifo_wr_en === 1'b1) begin
      check("write_queued", exp_data.size() != 0, 1);
      if (exp_data.size() != 0) check("din", fifo_din, exp_data.pop_front());
    end
    for (int i = 0; i < nr; i++)
      if (req_valid[i] && req_ready[i]) begin
        beat[i]++;
        remaining[i]--;
      end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data = '0;
    for (int i = 0; i < nr; i++) begin remaining[i] = 0; beat[i] = 0; end

    // Single requester: burst of 4, one idle cycle, then remaining 2 beats.
    do_reset();
    remaining[0] = 6; drive();
    idle(1); burst(0, 0, 4); idle(1); burst(0, 4, 2); held(0, 1); idle(1);
    run(10);
    drained("single");

    // All requesters valid: rotation with a burst of 4 and one idle cycle per grant.
    do_reset();
    remaining[0] = 8; remaining[1] = 4; remaining[2] = 4; remaining[3] = 4; drive();
`ifdef FIFO_WR_ARB_HIPRI_EN
    idle(1); burst(0, 0, 4); idle(1); burst(0, 4, 4); idle(1); burst(1, 0, 4); idle(1);
    burst(2, 0, 4); idle(1); burst(3, 0, 4); idle(1);
`else
    idle(1); burst(0, 0, 4); idle(1); burst(1, 0, 4); idle(1); burst(2, 0, 4); idle(1);
    burst(3, 0, 4); idle(1); burst(0, 4, 4); idle(1);
`endif
    run(26);
    drained("rotate");

    // Requester 2 stalled by fifo_full for 3 cycles after beat 2.
    do_reset();
    remaining[2] = 4; drive();
    idle(1); burst(2, 0, 2); held(2, 3); burst(2, 2, 2); idle(1);
    for (int c = 1; c <= 9; c++) begin
      step();
      fifo_full = (c >= 3 && c <= 5);
      if (c >= 3 && c <= 5) begin
        @(negedge clk);
        check("full_wr_en", fifo_wr_en, 0);
        check("full_ready", req_ready, 0);
        check("full_cnt", dut.cnt, 2);
        check("full_din", fifo_din, 8'h32);
      end
    end
    fifo_full = 1'b0;
    drained("full");

    // Requester 1 drops valid after one beat; next arbitration among 1001.
    do_reset();
    remaining[1] = 1; drive();
`ifdef FIFO_WR_ARB_HIPRI_EN
    idle(1); burst(1, 0, 1); held(1, 1); idle(1); burst(0, 0, 1); held(0, 1); idle(1);
    burst(3, 0, 1); held(3, 1); idle(1);
`else
    idle(1); burst(1, 0, 1); held(1, 1); idle(1); burst(3, 0, 1); held(3, 1); idle(1);
    burst(0, 0, 1); held(0, 1); idle(1);
`endif
    step();
    step();
    remaining[0] = 1; remaining[3] = 1; drive();
    step();
    @(negedge clk);
    check("drop_last", dut.last, 1);
    run(7);
    drained("drop");

    // Reset mid-burst of requester 3, then all requesters valid for one beat each.
    do_reset();
    remaining[3] = 8; drive();
    idle(1); burst(3, 0, 2); held(3, 1); idle(1);
    burst(0, 0, 1); held(0, 1); idle(1); burst(1, 0, 1); held(1, 1); idle(1);
    burst(2, 0, 1); held(2, 1); idle(1); burst(3, 0, 1); held(3, 1); idle(1);
    step();
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_wr_en", fifo_wr_en, 0);
    check("rstmid_ready", req_ready, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < nr; i++) begin remaining[i] = 1; beat[i] = 0; end
    drive();
    @(negedge clk);
    check("rstmid_busy", busy, 0);
    check("rstmid_grant", grant, 0);
    check("rstmid_no_write", fifo_wr_en, 0);
    run(13);
    drained("rstmid");

    // Requesters 0 and 2 held valid with last = 0.
    do_reset();
    remaining[0] = 1; drive();
    idle(1); burst(0, 0, 1); held(0, 1); idle(1);
`ifdef FIFO_WR_ARB_HIPRI_EN
    burst(0, 1, 4); idle(1); burst(0, 5, 4); idle(1); burst(2, 0, 4); idle(1); burst(2, 4, 4); idle(1);
`else
    burst(2, 0, 4); idle(1); burst(0, 1, 4); idle(1); burst(2, 4, 4); idle(1); burst(0, 5, 4); idle(1);
`endif
    step();
    step();
    step();
    remaining[0] = 8; remaining[2] = 8; drive();
    @(negedge clk);
    check("pri_last", dut.last, 0);
    run(21);
    drained("pri");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
